// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared types and constants for the pipeline sequencing controller.
//   state_t        : controller state (RUN / WAIT / ERROR)
//   REG0           : hard-wired zero register, never a real dependency
//   CNT_W_DEFAULT  : default width of the performance counters
//   src_match()    : RAW compare of the ID sources against one destination
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [4:0] REG0          = 5'd0;
    localparam int         CNT_W_DEFAULT = 16;

    // True when the ID instruction reads 'dest'. src2 only counts when the
    // instruction actually reads it. A write to r0 is discarded by the
    // register file, so it can never create a dependency.
    function automatic logic src_match(
        input logic [4:0] src1,
        input logic [4:0] src2,
        input logic       two_src,
        input logic [4:0] dest
    );
        return ((src1 == dest) || (two_src && (src2 == dest))) && (dest != REG0);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
// Bundle between the pipeline datapath and the sequencing controller.
//   Status from the datapath : src1, src2, two_src, exe_dest, exe_wb_en,
//                              exe_mem_read, mem_dest, mem_wb_en, br_taken,
//                              mem_req, mem_ready
//   Controls to the datapath : pc_en, if_id_en, id_exe_en, exe_mem_en,
//                              mem_wb_reg_en, if_id_flush, id_exe_flush
//   Status from controller   : stall_cnt, flush_cnt, mem_timeout, state
// Memory handshake: mem_req marks an access held in EXE/MEM; the access
// completes in the cycle mem_ready is high. While mem_req is high and
// mem_ready is low the whole pipe is frozen.
// modport master : datapath side; modport slave : controller side.
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
);
    logic [4:0]       src1;
    logic [4:0]       src2;
    logic             two_src;
    logic [4:0]       exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_read;
    logic [4:0]       mem_dest;
    logic             mem_wb_en;
    logic             br_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_en;
    logic             if_id_en;
    logic             id_exe_en;
    logic             exe_mem_en;
    logic             mem_wb_reg_en;
    logic             if_id_flush;
    logic             id_exe_flush;

    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;
    state_t           state;

    modport master (
        output src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_read,
               mem_dest, mem_wb_en, br_taken, mem_req, mem_ready,
        input  pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_reg_en,
               if_id_flush, id_exe_flush, stall_cnt, flush_cnt,
               mem_timeout, state
    );

    modport slave (
        input  src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_read,
               mem_dest, mem_wb_en, br_taken, mem_req, mem_ready,
        output pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_reg_en,
               if_id_flush, id_exe_flush, stall_cnt, flush_cnt,
               mem_timeout, state
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect
// Combinational RAW hazard detection for the ID-stage instruction.
//   FORWARD_EN=1 : forwarding covers everything except a load in EXE, so
//                  only a load-use match raises hazard.
//   FORWARD_EN=0 : any pending write in EXE or MEM raises hazard.
// Ports: src1, src2, two_src (ID sources), exe_dest/exe_wb_en/exe_mem_read
// (ID/EXE), mem_dest/mem_wb_en (EXE/MEM), hazard (out).
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic [4:0] src1,
    input  logic [4:0] src2,
    input  logic       two_src,
    input  logic [4:0] exe_dest,
    input  logic       exe_wb_en,
    input  logic       exe_mem_read,
    input  logic [4:0] mem_dest,
    input  logic       mem_wb_en,
    output logic       hazard
);

    logic exe_hit;
    logic mem_hit;

    always_comb begin
        exe_hit = src_match(src1, src2, two_src, exe_dest) &&
                  (FORWARD_EN ? exe_mem_read : exe_wb_en);
        // With forwarding, MEM results are always bypassed and never stall.
        mem_hit = src_match(src1, src2, two_src, mem_dest) && mem_wb_en &&
                  !FORWARD_EN;
        hazard  = exe_hit || mem_hit;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline sequencing controller for the 5-stage core. Drives the load
// enables and bubble flushes of PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB.
// Output priority: reset/ERROR > memory freeze > taken branch > hazard.
// A watchdog locks into ERROR after MEM_TIMEOUT consecutive freeze cycles
// (0 disables it); only rst leaves ERROR. Two saturating counters record
// stall cycles (freeze or hazard) and branch flushes.
// Ports: clk, rst (sync, active high), bus (pipe_hazard_ctrl_if.slave).
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter bit FORWARD_EN  = 1'b1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   bus
);

    // wait_cnt only needs to reach MEM_TIMEOUT-1.
    localparam int              WCW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           state;
    state_t           state_next;
    logic [WCW-1:0]   wait_cnt;
    logic [WCW-1:0]   wait_cnt_next;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic freeze;
    logic hazard;
    logic do_stall;
    logic do_flush;

    logic pc_en;
    logic if_id_en;
    logic id_exe_en;
    logic exe_mem_en;
    logic mem_wb_reg_en;
    logic if_id_flush;
    logic id_exe_flush;

    assign freeze = bus.mem_req && !bus.mem_ready;

    hazard_detect #(
        .FORWARD_EN (FORWARD_EN)
    ) u_hazard_detect (
        .src1         (bus.src1),
        .src2         (bus.src2),
        .two_src      (bus.two_src),
        .exe_dest     (bus.exe_dest),
        .exe_wb_en    (bus.exe_wb_en),
        .exe_mem_read (bus.exe_mem_read),
        .mem_dest     (bus.mem_dest),
        .mem_wb_en    (bus.mem_wb_en),
        .hazard       (hazard)
    );

    // Pipeline controls, zero-cycle latency from the inputs.
    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_exe_en     = 1'b0;
        exe_mem_en    = 1'b0;
        mem_wb_reg_en = 1'b0;
        if_id_flush   = 1'b0;
        id_exe_flush  = 1'b0;
        do_stall      = 1'b0;
        do_flush      = 1'b0;
        if (rst || state == ERROR) begin
            // Everything held; nothing counted.
        end else if (freeze) begin
            do_stall = 1'b1;
        end else if (bus.br_taken) begin
            // A hazarding instruction in ID is squashed by the flush, so
            // the branch takes precedence over the stall.
            pc_en         = 1'b1;
            if_id_en      = 1'b1;
            id_exe_en     = 1'b1;
            exe_mem_en    = 1'b1;
            mem_wb_reg_en = 1'b1;
            if_id_flush   = 1'b1;
            id_exe_flush  = 1'b1;
            do_flush      = 1'b1;
        end else if (hazard) begin
            // Hold PC and IF/ID, send a bubble into EXE, drain the back end.
            id_exe_en     = 1'b1;
            id_exe_flush  = 1'b1;
            exe_mem_en    = 1'b1;
            mem_wb_reg_en = 1'b1;
            do_stall      = 1'b1;
        end else begin
            pc_en         = 1'b1;
            if_id_en      = 1'b1;
            id_exe_en     = 1'b1;
            exe_mem_en    = 1'b1;
            mem_wb_reg_en = 1'b1;
        end
    end

    // Next state and watchdog count. wait_cnt holds the number of freeze
    // cycles already seen, so in cycle k of a freeze it reads k-1 and the
    // ERROR edge falls at the end of cycle MEM_TIMEOUT.
    always_comb begin
        state_next    = state;
        wait_cnt_next = '0;
        case (state)
            RUN: begin
                if (freeze) begin
                    wait_cnt_next = WCW'(1);
                    state_next    = (MEM_TIMEOUT == 1) ? ERROR : WAIT;
                end
            end
            WAIT: begin
                if (!freeze) begin
                    state_next = RUN;
                end else if (MEM_TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
                    state_next = ERROR;
                end else begin
                    // Saturates so a disabled watchdog cannot wrap.
                    wait_cnt_next = (wait_cnt == '1) ? wait_cnt : wait_cnt + WCW'(1);
                end
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (do_stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (do_flush && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.pc_en         = pc_en;
    assign bus.if_id_en      = if_id_en;
    assign bus.id_exe_en     = id_exe_en;
    assign bus.exe_mem_en    = exe_mem_en;
    assign bus.mem_wb_reg_en = mem_wb_reg_en;
    assign bus.if_id_flush   = if_id_flush;
    assign bus.id_exe_flush  = id_exe_flush;
    assign bus.stall_cnt     = stall_cnt;
    assign bus.flush_cnt     = flush_cnt;
    assign bus.mem_timeout   = (state == ERROR);
    assign bus.state         = state;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It owns the enable and flush controls of the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers. It resolves load-use hazards by inserting a bubble, flushes the front end on a taken branch, and freezes the whole pipe while the data memory is busy. A timeout watchdog and two saturating performance counters provide the sequential state.

## Interface

Parameters:
- FORWARD_EN, 1: 1 means the forwarding unit is present, so only load-use stalls; 0 means any RAW match against EXE or MEM stalls.
- MEM_TIMEOUT, 64: consecutive freeze cycles before the error lock; 0 disables the watchdog.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- src1, src2  in  5  ID-stage source register numbers.
- two_src  in  1  ID instruction reads src2 (not an immediate/store-data-only form).
- exe_dest  in  5  destination held in ID/EXE.
- exe_wb_en, exe_mem_read  in  1  ID/EXE control bits.
- mem_dest  in  5  destination held in EXE/MEM.
- mem_wb_en  in  1  EXE/MEM write-back enable.
- br_taken  in  1  branch resolved taken in EXE this cycle.
- mem_req  in  1  EXE/MEM holds a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_reg_en  out  1  register load enables.
- if_id_flush, id_exe_flush  out  1  load zeros (bubble) into the register; overrides the data, requires the matching enable.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.
- mem_timeout  out  1  sticky watchdog error.

## Operation

- freeze = mem_req & !mem_ready.
- hazard is the OR of two terms. Register 0 never matches.
  - exe term: (src1==exe_dest | two_src & src2==exe_dest) & exe_dest!=0, qualified by exe_mem_read when FORWARD_EN=1 and by exe_wb_en when FORWARD_EN=0.
  - mem term, FORWARD_EN=0 only: the same comparison against mem_dest, qualified by mem_wb_en.
- Control outputs are combinational. Priority, highest first:
  1. rst=1 or state ERROR: all enables 0, all flushes 0.
  2. freeze: all enables 0, all flushes 0. The pipe holds.
  3. br_taken: all enables 1, if_id_flush=1, id_exe_flush=1. The PC loads the target.
  4. hazard: pc_en=0, if_id_en=0, id_exe_en=1, id_exe_flush=1, exe_mem_en=1, mem_wb_reg_en=1.
  5. otherwise: all enables 1, all flushes 0.
- When br_taken and hazard occur together, the branch wins; the hazarding instruction is flushed anyway.
- FSM states (enum):
  - RUN → WAIT on freeze.
  - WAIT → RUN when freeze drops.
  - WAIT → ERROR on the edge where freeze is still high and wait_cnt==MEM_TIMEOUT-1.
  - ERROR is exited only by rst.
- wait_cnt counts consecutive freeze cycles. It clears in RUN and when freeze drops.
- flush_cnt increments on each edge where case 3 applies. stall_cnt increments on each edge where case 4 or case 2 applies. Both saturate at all-ones and do not wrap.
- mem_timeout = (state==ERROR).

## Timing

- Reset values: state RUN, wait_cnt 0, stall_cnt 0, flush_cnt 0, mem_timeout 0. While rst is high, enables and flushes are 0.
- Control outputs have zero-cycle latency from their inputs. Counters and state update on the next rising edge.
- A load-use hazard costs exactly 1 bubble cycle. On the following cycle exe_mem_read refers to the bubble (0), so the hazard clears.
- Freeze lasting N cycles, with N < MEM_TIMEOUT: enables are 0 for exactly N cycles and resume in the cycle mem_ready rises.
- With MEM_TIMEOUT=T, mem_timeout rises in cycle T+1 of a continuous freeze.
- rst asserted mid-freeze or in ERROR returns to RUN on the next edge.

## Structure

- pipe_ctrl_pkg holds:
  - the state enum {RUN, WAIT, ERROR};
  - the REG0 constant;
  - the default for the CNT_W parameter.
- One sub-module, hazard_detect: combinational source/destination compare, parameterised by FORWARD_EN, output hazard.
- The FSM, watchdog and counters sit in the top module.

## Test plan

- Load-use: exe_mem_read=1, exe_dest=5, src1=5 → for one cycle pc_en=0, if_id_en=0, id_exe_flush=1; then all enables 1; stall_cnt=1.
- Register-0 and forwarding filter: exe_dest=0 with a matching src1 → no stall. With FORWARD_EN=1, exe_wb_en=1, exe_mem_read=0 and a match → no stall. With FORWARD_EN=0, the same case stalls.
- Branch over hazard: br_taken=1 together with a load-use match → if_id_flush=1, id_exe_flush=1, pc_en=1; flush_cnt=1; stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 → all enables 0 for 3 cycles; stall_cnt=3; state returns to RUN.
- Timeout: MEM_TIMEOUT=4, mem_ready held at 0 → mem_timeout=1 in cycle 5 and stays high after mem_ready=1. rst clears it, and the counters read 0.
- Saturation: CNT_W=2 with 5 hazards → stall_cnt=3.
